avst_pixel_sink: RTL and testbench
==================================

AVST_PIXEL_SINK -- requirements
Module: avst_pixel_sink

Interface
REQ-001 SHALL have parameter H_PIXELS, default 320, meaning pixels per line.
REQ-002 SHALL have parameter V_LINES, default 240, meaning lines per frame; NUM_PIXELS = H_PIXELS*V_LINES.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, meaning buffer entries (power of 2, >=4).
REQ-004 SHALL have port clk  input  1  the single system clock.
REQ-005 SHALL have port reset  input  1  asynchronous reset, active-high.
REQ-006 SHALL have port data  input  30  Avalon-ST pixel as {R[9:0],G[9:0],B[9:0]}, each channel 8 colour bits then 2 pad bits.
REQ-007 SHALL have ports startofpacket, endofpacket, valid  input  1 each  Avalon-ST framing and qualifier.
REQ-008 SHALL have port ready  output  1  Avalon-ST backpressure, ready latency 0.
REQ-009 SHALL have port pix_req  input  1  display-side pull request, one pixel per asserted cycle.
REQ-010 SHALL have ports pix_data  output  24  {R8,G8,B8}; pix_valid  output  1; pix_sof  output  1  first pixel of frame.
REQ-011 SHALL have ports frame_done, frame_err, underflow  output  1 each  single-cycle pulses.
REQ-012 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy.

Function
REQ-013 SHALL accept a beat only in a cycle where valid & ready; ready = ~reset & (fifo_level < FIFO_DEPTH), combinational from registered occupancy.
REQ-014 SHALL strip pad bits: stored RGB = {data[29:22],data[19:12],data[9:2]}, plus a 1-bit sof flag (25-bit entry).
REQ-015 SHALL implement states WAIT_SOP and IN_FRAME with a pixel counter of width $clog2(NUM_PIXELS)+1.
REQ-016 WAIT_SOP: accepted beats without startofpacket SHALL be discarded (not written); a beat with startofpacket SHALL be written with sof=1, counter=1, go IN_FRAME.
REQ-017 IN_FRAME: each accepted beat SHALL be written and counter incremented.
REQ-018 IN_FRAME, endofpacket on beat number NUM_PIXELS: frame_done pulse next cycle, go WAIT_SOP.
REQ-019 IN_FRAME, endofpacket before beat NUM_PIXELS, or beat NUM_PIXELS without endofpacket: beat written, frame_err pulse, go WAIT_SOP.
REQ-020 IN_FRAME, startofpacket mid-frame: frame_err pulse, beat written with sof=1, counter=1, stay IN_FRAME.
REQ-021 A single-beat frame (SOP and EOP together) SHALL be legal only if NUM_PIXELS==1, otherwise frame_err.
REQ-022 Read side: pix_req with fifo_level>0 at cycle start SHALL pop; pix_data/pix_sof registered, pix_valid=1 the following cycle (latency 1).
REQ-023 pix_req with fifo_level==0 SHALL give underflow pulse, pix_valid=0, pix_data=0 next cycle; a same-cycle push is not visible to that read.
REQ-024 Simultaneous push and pop SHALL leave fifo_level unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-025 pix_valid SHALL be 0 in any cycle not following a successful pop.

Reset
REQ-026 Reset SHALL clear pointers, fifo_level=0, counter=0, state=WAIT_SOP; ready=0, pix_valid=0, pix_sof=0, pix_data=0, all pulses 0.
REQ-027 Reset mid-frame SHALL discard buffered pixels; after release the sink resyncs at the next startofpacket.

Configuration
REQ-028 Macro AVST_SINK_ERR_CNT_EN defined: output err_count 16 bits, incremented on each frame_err or underflow pulse (by 2 if both), saturating at 16'hFFFF, reset to 0.
REQ-029 Macro undefined: err_count port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-030 Package avst_pixel_pkg SHALL hold the rgb888 struct typedef, the fifo entry typedef {sof, rgb888}, the state enum, and default geometry constants 320/240.
REQ-031 FIFO storage and pointers SHALL be sub-module sync_fifo (parameterised width/depth, occupancy output); framing FSM and read register stay in avst_pixel_sink.

Verification
REQ-032 H_PIXELS=4,V_LINES=2: SOP beat, 6 beats, EOP beat, pix_req held -> 8 pixels out in order, pix_sof only on first, frame_done one pulse, no frame_err.
REQ-033 3 beats without SOP then a legal frame -> first 3 discarded, fifo_level never counts them, frame output intact.
REQ-034 EOP on beat 5 of 8 -> frame_err pulse, 5 pixels buffered, state WAIT_SOP; next SOP accepted normally.
REQ-035 pix_req=0, 20 valid beats streamed -> ready falls when fifo_level=16, 16 accepted, source stalls; one pix_req -> ready re-asserts next cycle.
REQ-036 pix_req with empty FIFO -> underflow pulse, pix_valid=0, pix_data=24'h0; with AVST_SINK_ERR_CNT_EN, err_count 0->1.
REQ-037 reset asserted after 3 beats of a frame -> ready=0 and fifo_level=0 immediately; post-release, non-SOP beats discarded until SOP.

Source files
------------

// File: rtl/avst_pixel_pkg.sv
// avst_pixel_pkg: shared pixel, buffer-entry and framing-state types plus default frame geometry.
package avst_pixel_pkg;
   localparam int DEF_H_PIXELS = 320;
   localparam int DEF_V_LINES  = 240;
   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb888_t;
   typedef struct packed {
      logic    sof;
      rgb888_t rgb;
   } fifo_entry_t;
   typedef enum logic {WAIT_SOP, IN_FRAME} state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with occupancy output; depth must be a power of 2.
module sync_fifo #(
   parameter int WIDTH = 25,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic push, pop;
   assign push = wr_en & (level < (AW+1)'(DEPTH));
   assign pop = rd_en & (level != '0);
   assign rd_data = mem[rptr];
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
         level <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop) rptr <= rptr + AW'(1);
         level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
   always_ff @(posedge clk)
      if (push) mem[wptr] <= wr_data;
endmodule

// File: rtl/avst_pixel_sink.sv
// avst_pixel_sink: Avalon-ST video sink that frames, buffers and serves RGB888 pixels on demand.
// Define AVST_SINK_ERR_CNT_EN to add the saturating err_count output.
module avst_pixel_sink import avst_pixel_pkg::*; #(
   parameter int H_PIXELS   = DEF_H_PIXELS,
   parameter int V_LINES    = DEF_V_LINES,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [29:0]                   data,
   input  logic                          startofpacket,
   input  logic                          endofpacket,
   input  logic                          valid,
   output logic                          ready,
   input  logic                          pix_req,
   output logic [23:0]                   pix_data,
   output logic                          pix_valid,
   output logic                          pix_sof,
   output logic                          frame_done,
   output logic                          frame_err,
   output logic                          underflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef AVST_SINK_ERR_CNT_EN
   ,output logic [15:0]                  err_count
`endif
);
   localparam int NUM_PIXELS = H_PIXELS * V_LINES;
   localparam int CW = $clog2(NUM_PIXELS) + 1;
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   state_t state;
   logic [CW-1:0] cnt, cnt_nxt;
   logic accept, wr_en, rd_en, last;
   fifo_entry_t wr_entry, rd_entry;
   assign ready = ~reset & (fifo_level < LW'(FIFO_DEPTH));
   assign accept = valid & ready;
   assign wr_en = accept & ((state == IN_FRAME) | startofpacket);
   assign cnt_nxt = startofpacket ? CW'(1) : cnt + CW'(1);
   assign last = cnt_nxt == CW'(NUM_PIXELS);
   assign wr_entry = '{sof: startofpacket, rgb: '{r: data[29:22], g: data[19:12], b: data[9:2]}};
   assign rd_en = pix_req & (fifo_level != '0);
   sync_fifo #(.WIDTH($bits(fifo_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .reset(reset),
      .wr_en(wr_en),
      .wr_data(wr_entry),
      .rd_en(rd_en),
      .rd_data(rd_entry),
      .level(fifo_level)
   );
   // A frame ends on EOP or on its last beat; anything but both together is an error.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= WAIT_SOP;
         cnt <= '0;
         frame_done <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_done <= wr_en & endofpacket & last;
         frame_err <= wr_en & (((state == IN_FRAME) & startofpacket) | (endofpacket ^ last));
         if (wr_en) begin
            cnt <= cnt_nxt;
            state <= (endofpacket | last) ? WAIT_SOP : IN_FRAME;
         end
      end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         pix_valid <= 1'b0;
         pix_sof <= 1'b0;
         pix_data <= '0;
         underflow <= 1'b0;
      end else begin
         pix_valid <= rd_en;
         pix_sof <= rd_en & rd_entry.sof;
         pix_data <= rd_en ? rd_entry.rgb : '0;
         underflow <= pix_req & ~rd_en;
      end
`ifdef AVST_SINK_ERR_CNT_EN
   logic [16:0] err_sum;
   assign err_sum = {1'b0, err_count} + 17'(frame_err) + 17'(underflow);
   always_ff @(posedge clk or posedge reset)
      if (reset) err_count <= '0;
      else err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
`endif
endmodule

// File: tb/tb_avst_pixel_sink.sv
// tb_avst_pixel_sink: directed self-checking bench for avst_pixel_sink with an 8-pixel frame.
module tb_avst_pixel_sink;
   logic clk = 1'b0, reset = 1'b1;
   logic [29:0] data = '0;
   logic startofpacket = 1'b0, endofpacket = 1'b0, valid = 1'b0, pix_req = 1'b0;
   logic ready, pix_valid, pix_sof, frame_done, frame_err, underflow;
   logic [23:0] pix_data;
   logic [4:0] fifo_level;
`ifdef AVST_SINK_ERR_CNT_EN
   logic [15:0] err_count;
   logic [15:0] ec0;
`endif
   int n_chk = 0, n_fail = 0, n_done = 0, n_err = 0;
   int d0, e0, acc;
   logic [24:0] exp_q[$];
   logic [24:0] e;
   always #5 clk = ~clk;
   avst_pixel_sink #(.H_PIXELS(4), .V_LINES(2), .FIFO_DEPTH(16)) dut (
      .clk(clk),
      .reset(reset),
      .data(data),
      .startofpacket(startofpacket),
      .endofpacket(endofpacket),
      .valid(valid),
      .ready(ready),
      .pix_req(pix_req),
      .pix_data(pix_data),
      .pix_valid(pix_valid),
      .pix_sof(pix_sof),
      .frame_done(frame_done),
      .frame_err(frame_err),
      .underflow(underflow),
      .fifo_level(fifo_level)
`ifdef AVST_SINK_ERR_CNT_EN
      ,.err_count(err_count)
`endif
   );
   always @(negedge clk) begin
      n_done += int'(frame_done);
      n_err += int'(frame_err);
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   function automatic logic [29:0] enc(input logic [23:0] p);
      return {p[23:16], 2'b11, p[15:8], 2'b01, p[7:0], 2'b10};
   endfunction
   function automatic logic [23:0] pix(input int i);
      logic [7:0] b;
      b = 8'(i);
      return {b, ~b, b ^ 8'h5A};
   endfunction
   task automatic send(input logic sop, input logic eop, input logic [23:0] p, input logic keep);
      valid = 1'b1;
      startofpacket = sop;
      endofpacket = eop;
      data = enc(p);
      tick;
      valid = 1'b0;
      startofpacket = 1'b0;
      endofpacket = 1'b0;
      if (keep) exp_q.push_back({sop, p});
   endtask
   task automatic drain;
      int n;
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         pix_req = 1'b1;
         tick;
         e = exp_q.pop_front();
         check("pix_valid", 32'(pix_valid), 32'(1));
         check("pix_data", 32'(pix_data), 32'(e[23:0]));
         check("pix_sof", 32'(pix_sof), 32'(e[24]));
      end
      pix_req = 1'b0;
      check("drain_lvl", 32'(fifo_level), 32'(0));
      tick;
      check("valid_idle", 32'(pix_valid), 32'(0));
   endtask
   initial begin
      tick;
      check("rst_ready", 32'(ready), 32'(0));
      check("rst_lvl", 32'(fifo_level), 32'(0));
      check("rst_pvalid", 32'(pix_valid), 32'(0));
      check("rst_pdata", 32'(pix_data), 32'(0));
      check("rst_psof", 32'(pix_sof), 32'(0));
      check("rst_pulses", 32'({frame_done, frame_err, underflow}), 32'(0));
      reset = 1'b0;
      #1;
      check("ready_up", 32'(ready), 32'(1));
      // junk before SOP, then a legal frame
      d0 = n_done;
      e0 = n_err;
      for (int i = 0; i < 3; i++) begin
         send(1'b0, 1'b0, pix(100 + i), 1'b0);
         check("discard_lvl", 32'(fifo_level), 32'(0));
      end
      for (int i = 0; i < 8; i++) send(i == 0, i == 7, pix(i), 1'b1);
      check("done_pulse", 32'(frame_done), 32'(1));
      check("frame_lvl", 32'(fifo_level), 32'(8));
      tick;
      check("done_once", 32'(n_done - d0), 32'(1));
      check("no_err", 32'(n_err - e0), 32'(0));
      drain;
      // early EOP on beat 5
      d0 = n_done;
      e0 = n_err;
      for (int i = 0; i < 5; i++) send(i == 0, i == 4, pix(20 + i), 1'b1);
      check("err_pulse", 32'(frame_err), 32'(1));
      check("short_lvl", 32'(fifo_level), 32'(5));
      send(1'b0, 1'b0, pix(99), 1'b0);
      check("wait_sop_lvl", 32'(fifo_level), 32'(5));
      tick;
      check("err_once", 32'(n_err - e0), 32'(1));
      drain;
      for (int i = 0; i < 8; i++) send(i == 0, i == 7, pix(40 + i), 1'b1);
      tick;
      check("resync_done", 32'(n_done - d0), 32'(1));
      check("resync_err", 32'(n_err - e0), 32'(1));
      drain;
      // underflow
`ifdef AVST_SINK_ERR_CNT_EN
      ec0 = err_count;
`endif
      pix_req = 1'b1;
      tick;
      pix_req = 1'b0;
      check("udf_pulse", 32'(underflow), 32'(1));
      check("udf_valid", 32'(pix_valid), 32'(0));
      check("udf_data", 32'(pix_data), 32'(0));
      tick;
      check("udf_single", 32'(underflow), 32'(0));
`ifdef AVST_SINK_ERR_CNT_EN
      check("err_count", 32'(err_count), 32'(ec0) + 32'(1));
`endif
      // backpressure: 20 beats into a 16-entry buffer
      acc = 0;
      valid = 1'b1;
      startofpacket = 1'b1;
      for (int i = 0; i < 20; i++) begin
         data = enc(pix(60 + i));
         acc += int'(ready);
         if (i < 16) exp_q.push_back({1'b1, pix(60 + i)});
         tick;
      end
      check("accepted", 32'(acc), 32'(16));
      check("full_lvl", 32'(fifo_level), 32'(16));
      check("full_ready", 32'(ready), 32'(0));
      pix_req = 1'b1;
      tick;
      pix_req = 1'b0;
      valid = 1'b0;
      startofpacket = 1'b0;
      e = exp_q.pop_front();
      check("ready_back", 32'(ready), 32'(1));
      check("pop_lvl", 32'(fifo_level), 32'(15));
      check("pop_data", 32'(pix_data), 32'(e[23:0]));
      check("pop_sof", 32'(pix_sof), 32'(e[24]));
      drain;
      // reset mid-frame
      for (int i = 0; i < 3; i++) send(i == 0, 1'b0, pix(90 + i), 1'b0);
      check("pre_rst_lvl", 32'(fifo_level), 32'(3));
      #2;
      reset = 1'b1;
      #1;
      check("arst_ready", 32'(ready), 32'(0));
      check("arst_lvl", 32'(fifo_level), 32'(0));
      tick;
      reset = 1'b0;
      for (int i = 0; i < 2; i++) send(1'b0, 1'b0, pix(95 + i), 1'b0);
      check("post_rst_discard", 32'(fifo_level), 32'(0));
      send(1'b1, 1'b0, pix(97), 1'b1);
      check("post_rst_sop", 32'(fifo_level), 32'(1));
      drain;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
